// File: rtl/reg_div_seq_pkg.sv
// Shared definitions for the sequential register-bank divider: controller
// states, default widths and the fixed number of restoring iterations.
package reg_div_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IDX_W_DEF  = 4;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_DIV  = 3'd2,
        ST_WR_Q = 3'd3,
        ST_WR_R = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/reg_div_seq_div_iter.sv
// One step of unsigned restoring division: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module div_iter
    import reg_div_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              next_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    // One extra bit because the shifted remainder can reach 2*divisor-1.
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // Trial subtract; a clear top bit means no borrow, so the quotient bit is 1.
    always_comb begin
        shifted = {rem_in, next_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[DATA_W];
        rem_out = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/reg_div_seq.sv
// Sequential divider working on an external register bank: reads two
// operands, runs a bit-serial restoring divide, writes quotient then
// remainder back, and pulses done.
module reg_div_seq
    import reg_div_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              reset_all,
    input  logic              start,
    input  logic [IDX_W-1:0]  src_a,
    input  logic [IDX_W-1:0]  src_b,
    input  logic [IDX_W-1:0]  dst_q,
    input  logic [IDX_W-1:0]  dst_r,
    output logic [IDX_W-1:0]  rs,
    output logic [IDX_W-1:0]  rt,
    output logic [IDX_W-1:0]  rd,
    output logic              read,
    output logic              write,
    output logic              enable,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  src_a_reg, src_b_reg, dst_q_reg, dst_r_reg;
    logic [DATA_W-1:0] divisor_reg;
    logic [DATA_W-1:0] quo_reg;   // holds the dividend, shifted out as quotient bits shift in
    logic [DATA_W-1:0] rem_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              dbz_reg;

    logic [DATA_W-1:0] rem_step;
    logic              q_step;

    div_iter #(.DATA_W(DATA_W)) u_iter (
        .rem_in   (rem_reg),
        .next_bit (quo_reg[DATA_W-1]),
        .divisor  (divisor_reg),
        .rem_out  (rem_step),
        .q_bit    (q_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset_all) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a zero divisor bypasses the iterations entirely.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_READ;
            ST_READ: state_next = (rdata2 == '0) ? ST_WR_Q : ST_DIV;
            ST_DIV:  if (cnt_reg == CNT_W'(ITER_COUNT - 1)) state_next = ST_WR_Q;
            ST_WR_Q: state_next = ST_WR_R;
            ST_WR_R: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Index capture, operand load, iteration datapath and sticky zero flag.
    always_ff @(posedge clk) begin
        if (reset_all) begin
            src_a_reg   <= '0;
            src_b_reg   <= '0;
            dst_q_reg   <= '0;
            dst_r_reg   <= '0;
            divisor_reg <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        src_a_reg <= src_a;
                        src_b_reg <= src_b;
                        dst_q_reg <= dst_q;
                        dst_r_reg <= dst_r;
                        dbz_reg   <= 1'b0;
                    end
                end
                ST_READ: begin
                    divisor_reg <= rdata2;
                    cnt_reg     <= '0;
                    if (rdata2 == '0) begin
                        quo_reg <= '1;
                        rem_reg <= rdata1;
                        dbz_reg <= 1'b1;
                    end else begin
                        quo_reg <= rdata1;
                        rem_reg <= '0;
                    end
                end
                ST_DIV: begin
                    quo_reg <= {quo_reg[DATA_W-2:0], q_step};
                    rem_reg <= rem_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state; idle drives everything low.
    always_comb begin
        rs     = '0;
        rt     = '0;
        rd     = '0;
        read   = 1'b0;
        write  = 1'b0;
        wdata  = '0;
        busy   = (state_reg != ST_IDLE);
        done   = (state_reg == ST_DONE);
        case (state_reg)
            ST_READ: begin
                rs   = src_a_reg;
                rt   = src_b_reg;
                read = 1'b1;
            end
            ST_WR_Q: begin
                rd    = dst_q_reg;
                wdata = quo_reg;
                write = 1'b1;
            end
            ST_WR_R: begin
                rd    = dst_r_reg;
                wdata = rem_reg;
                write = 1'b1;
            end
            default: ;
        endcase
        enable      = read | write;
        div_by_zero = dbz_reg;
    end

endmodule

// File: doc/reg_div_seq.md
REG_DIV_SEQ -- requirements
Module: reg_div_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 SHALL have parameter IDX_W, default 4, meaning register-index width (16 registers).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset_all  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a divide; sampled only in IDLE.
REQ-006 SHALL have ports src_a, src_b, dst_q, dst_r  input  IDX_W each  dividend, divisor, quotient and remainder register indices; captured when start is accepted.
REQ-007 SHALL have ports rs, rt, rd  output  IDX_W each  register-bank read and write indices.
REQ-008 SHALL have ports read, write, enable  output  1 each  register-bank strobes.
REQ-009 SHALL have port wdata  output  DATA_W  register-bank write data.
REQ-010 SHALL have ports rdata1, rdata2  input  DATA_W each  register-bank read data for rs and rt; valid after the falling edge of the read cycle.
REQ-011 SHALL have ports busy, done, div_by_zero  output  1 each  status flags.

Function
REQ-012 SHALL implement FSM states IDLE, READ, DIV, WR_Q, WR_R, DONE.
REQ-013 IDLE: start=1 at edge E0 SHALL capture all four indices and go to READ; start while not IDLE SHALL be ignored.
REQ-014 READ, one cycle: rs=src_a, rt=src_b, read=1, enable=1; at E1 SHALL capture rdata1 as dividend and rdata2 as divisor, then go to DIV.
REQ-015 DIV: unsigned restoring division, one quotient bit per cycle, 32 iterations on edges E2..E33, then WR_Q.
REQ-016 Divisor 0 at E1 SHALL skip the iterations: quotient=all ones, remainder=dividend, div_by_zero=1, state moves straight to WR_Q.
REQ-017 WR_Q, one cycle: rd=dst_q, wdata=quotient, write=1, enable=1; then WR_R.
REQ-018 WR_R, one cycle: rd=dst_r, wdata=remainder, write=1, enable=1; then DONE.
REQ-019 When dst_q==dst_r, both writes SHALL still issue, so the remainder is the final value.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Nominal latency: done high in the cycle after E35 (35 cycles after the start edge); divide-by-zero path SHALL reach done 32 cycles earlier.
REQ-022 read and write SHALL never be high in the same cycle; enable=read|write.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 div_by_zero SHALL hold from detection until the next accepted start or reset.
REQ-025 Outside READ, rs/rt SHALL be 0; outside WR_Q/WR_R, rd and wdata SHALL be 0.

Reset
REQ-026 reset_all=1 at any edge, including mid-DIV or mid-write, SHALL force IDLE and zero all outputs, the iteration counter and the operand, quotient and remainder registers.
REQ-027 reset_all SHALL take priority over start, and no register-bank write SHALL issue in the cycle after a reset edge.

Structure
REQ-028 A shared package SHALL hold the state enumeration, DATA_W/IDX_W defaults and the iteration count constant (32).
REQ-029 A single sub-module div_iter SHALL implement one restoring step (shifted remainder, trial subtract, quotient bit); the FSM and counter remain in reg_div_seq.

Verification
REQ-030 Normal divide: R1=100, R2=7, start src_a=1 src_b=2 dst_q=3 dst_r=4 -> R3=14, R4=2, done 35 cycles after the start edge, div_by_zero=0.
REQ-031 Divide by zero: R5=0x1234, R6=0 -> quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1, done 3 cycles after the start edge.
REQ-032 Edge values: 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, R=0; 5/9 -> Q=0, R=5.
REQ-033 Aliased destinations: dst_q=dst_r=8, 50/8 -> R8=2 at end; exactly two write cycles observed.
REQ-034 Reset mid-operation: reset_all=1 at iteration 10 -> next cycle busy=0, write=0, all outputs 0, no later bank writes; a fresh start then completes normally.
REQ-035 Start while busy: pulse start with different indices during DIV -> ignored; original destinations written, one done pulse.
